// File: rtl/runway_scheduler.sv
// Two-runway scheduler: queues landing/takeoff requests in FIFOs and grants
// runways one at a time, gated by the ECSU weather risk level.
module runway_scheduler #(
    parameter int DEPTH           = 4,
    parameter int ID_W            = 4,
    parameter int SEP_CYCLES      = 3,
    parameter int MAX_LAND_STREAK = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [1:0]              ECSU_state,
    input  logic                    land_req,
    input  logic [ID_W-1:0]         land_id,
    input  logic                    takeoff_req,
    input  logic [ID_W-1:0]         takeoff_id,
    input  logic [1:0]              runway_release,
    output logic                    grant_valid,
    output logic                    grant_is_landing,
    output logic [ID_W-1:0]         grant_id,
    output logic                    grant_runway,
    output logic [1:0]              runway_busy,
    output logic [$clog2(DEPTH):0]  land_count,
    output logic [$clog2(DEPTH):0]  takeoff_count,
    output logic                    land_overflow,
    output logic                    takeoff_overflow,
    output logic [1:0]              sched_state
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int SEP_W    = (SEP_CYCLES > 0) ? $clog2(SEP_CYCLES + 1) : 1;
    localparam int STREAK_W = (MAX_LAND_STREAK > 0) ? $clog2(MAX_LAND_STREAK + 1) : 1;

    localparam logic [1:0] RISK_CLEAR   = 2'b00;
    localparam logic [1:0] RISK_CAUTION = 2'b01;
    localparam logic [1:0] RISK_HIGH    = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_GRANT = 2'b01,
        S_HOLD  = 2'b11
    } state_t;

    state_t                 state_reg, state_next;
    logic [SEP_W-1:0]       sep_reg, sep_next;
    logic [STREAK_W-1:0]    streak_reg, streak_next;
    logic [1:0]             busy_reg, busy_next;
    logic                   grant_valid_reg;
    logic                   grant_land_reg;
    logic [ID_W-1:0]        grant_id_reg;
    logic                   grant_runway_reg;

    // Index 0 is the landing FIFO, index 1 the takeoff FIFO.
    logic [1:0]             push;
    logic [1:0]             pop;
    logic [1:0][ID_W-1:0]   din;
    logic [1:0][ID_W-1:0]   head;
    logic [1:0][CNT_W-1:0]  count;
    logic [1:0]             overflow;

    assign push = {takeoff_req, land_req};
    assign din  = {takeoff_id, land_id};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_fifo
            logic [ID_W-1:0]  mem [DEPTH];
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [CNT_W-1:0] count_reg;
            logic             overflow_reg;
            logic             full;
            logic             do_push;

            // Fullness uses the pre-edge count, so a same-edge pop never rescues a push.
            assign full    = (count_reg == CNT_W'(DEPTH));
            assign do_push = push[gi] && !full;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem[i] <= '0;
                    end
                    wr_ptr_reg   <= '0;
                    rd_ptr_reg   <= '0;
                    count_reg    <= '0;
                    overflow_reg <= 1'b0;
                end else begin
                    if (do_push) begin
                        mem[wr_ptr_reg] <= din[gi];
                        wr_ptr_reg      <= wr_ptr_reg + 1'b1;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    if (push[gi] && full) begin
                        overflow_reg <= 1'b1;
                    end
                    case ({do_push, pop[gi]})
                        2'b10:   count_reg <= count_reg + 1'b1;
                        2'b01:   count_reg <= count_reg - 1'b1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end

            assign head[gi]     = mem[rd_ptr_reg];
            assign count[gi]    = count_reg;
            assign overflow[gi] = overflow_reg;
        end
    endgenerate

    // Runway permissions per risk level
    logic [1:0] free;
    logic [1:0] land_rw_ok;
    logic [1:0] to_rw_ok;
    logic       land_elig;
    logic       to_elig;
    logic       pick_takeoff;
    logic       candidate;
    logic [1:0] sel_mask;
    logic       sel_runway;
    logic       do_grant;

    assign free = ~busy_reg;

    always_comb begin
        land_rw_ok = 2'b00;
        to_rw_ok   = 2'b00;
        case (ECSU_state)
            RISK_CLEAR: begin
                land_rw_ok = free;
                to_rw_ok   = free;
            end
            RISK_CAUTION: begin
                if (busy_reg == 2'b00) begin
                    land_rw_ok = free;
                    to_rw_ok   = free;
                end
            end
            RISK_HIGH: begin
                land_rw_ok = {1'b0, free[0]};
            end
            default: begin
                land_rw_ok = 2'b00;
                to_rw_ok   = 2'b00;
            end
        endcase
    end

    assign land_elig    = (count[0] != '0) && (land_rw_ok != 2'b00);
    assign to_elig      = (count[1] != '0) && (to_rw_ok != 2'b00);
    assign pick_takeoff = to_elig && (!land_elig || (streak_reg == STREAK_W'(MAX_LAND_STREAK)));
    assign candidate    = land_elig || to_elig;
    assign sel_mask     = pick_takeoff ? to_rw_ok : land_rw_ok;
    assign sel_runway   = ~sel_mask[0];

    always_comb begin
        state_next = state_reg;
        sep_next   = sep_reg;
        do_grant   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (candidate) begin
                    state_next = S_GRANT;
                    do_grant   = 1'b1;
                end
            end
            S_GRANT: begin
                if (SEP_CYCLES == 0) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_HOLD;
                    sep_next   = SEP_W'(SEP_CYCLES);
                end
            end
            S_HOLD: begin
                sep_next = sep_reg - 1'b1;
                if (sep_reg == SEP_W'(1)) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign pop = {do_grant && pick_takeoff, do_grant && !pick_takeoff};

    always_comb begin
        busy_next = busy_reg & ~runway_release;
        if (do_grant) begin
            busy_next[sel_runway] = 1'b1;
        end
    end

    // An empty takeoff queue means nobody is starving, so the streak restarts.
    always_comb begin
        streak_next = streak_reg;
        if ((count[1] == '0) || (do_grant && pick_takeoff)) begin
            streak_next = '0;
        end else if (do_grant && (streak_reg != STREAK_W'(MAX_LAND_STREAK))) begin
            streak_next = streak_reg + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg        <= S_IDLE;
            sep_reg          <= '0;
            streak_reg       <= '0;
            busy_reg         <= 2'b00;
            grant_valid_reg  <= 1'b0;
            grant_land_reg   <= 1'b0;
            grant_id_reg     <= '0;
            grant_runway_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            sep_reg         <= sep_next;
            streak_reg      <= streak_next;
            busy_reg        <= busy_next;
            grant_valid_reg <= do_grant;
            if (do_grant) begin
                grant_land_reg   <= !pick_takeoff;
                grant_id_reg     <= pick_takeoff ? head[1] : head[0];
                grant_runway_reg <= sel_runway;
            end
        end
    end

    assign grant_valid      = grant_valid_reg;
    assign grant_is_landing = grant_land_reg;
    assign grant_id         = grant_id_reg;
    assign grant_runway     = grant_runway_reg;
    assign runway_busy      = busy_reg;
    assign land_count       = count[0];
    assign takeoff_count    = count[1];
    assign land_overflow    = overflow[0];
    assign takeoff_overflow = overflow[1];
    assign sched_state      = state_reg;

endmodule

// File: tb/tb_runway_scheduler.sv
// Directed bench for runway_scheduler: expected grants are queued by the
// stimulus and popped by an independent grant monitor.
module tb_runway_scheduler;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [1:0] ECSU_state = 2'b00;
    logic       land_req = 1'b0;
    logic [3:0] land_id = 4'd0;
    logic       takeoff_req = 1'b0;
    logic [3:0] takeoff_id = 4'd0;
    logic [1:0] man_rel = 2'b00;
    logic [1:0] auto_rel = 2'b00;
    logic [1:0] runway_release;
    logic       grant_valid;
    logic       grant_is_landing;
    logic [3:0] grant_id;
    logic       grant_runway;
    logic [1:0] runway_busy;
    logic [2:0] land_count;
    logic [2:0] takeoff_count;
    logic       land_overflow;
    logic       takeoff_overflow;
    logic [1:0] sched_state;

    assign runway_release = man_rel | auto_rel;

    runway_scheduler #(
        .DEPTH(4), .ID_W(4), .SEP_CYCLES(3), .MAX_LAND_STREAK(3)
    ) dut (
        .CLK(CLK), .RST(RST), .ECSU_state(ECSU_state),
        .land_req(land_req), .land_id(land_id),
        .takeoff_req(takeoff_req), .takeoff_id(takeoff_id),
        .runway_release(runway_release),
        .grant_valid(grant_valid), .grant_is_landing(grant_is_landing),
        .grant_id(grant_id), .grant_runway(grant_runway),
        .runway_busy(runway_busy), .land_count(land_count),
        .takeoff_count(takeoff_count), .land_overflow(land_overflow),
        .takeoff_overflow(takeoff_overflow), .sched_state(sched_state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit       land;
        bit [3:0] id;
        bit       rw;
    } exp_t;

    exp_t exp_q[$];
    int   gcyc[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   auto_en = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Grant monitor: pops the scoreboard on every grant pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            auto_rel = 2'b00;
            if (grant_valid === 1'b1) begin
                gcyc.push_back(cyc);
                $display("grant: %s id=%0d runway=%0d cycle=%0d",
                         grant_is_landing ? "land" : "takeoff", grant_id, grant_runway, cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_grant: got id=%0d runway=%0d required none", grant_id, grant_runway);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_is_landing", 32'(grant_is_landing), 32'(e.land));
                    check("grant_id", 32'(grant_id), 32'(e.id));
                    check("grant_runway", 32'(grant_runway), 32'(e.rw));
                end
                if (auto_en) auto_rel[grant_runway] = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic expect_grant(input bit l, input bit [3:0] id, input bit rw);
        exp_t e;
        e.land = l;
        e.id   = id;
        e.rw   = rw;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit lv, input bit [3:0] li, input bit tv, input bit [3:0] ti);
        @(negedge CLK);
        land_req    = lv;
        land_id     = li;
        takeoff_req = tv;
        takeoff_id  = ti;
        man_rel     = 2'b00;
        $display("push: land=%0d id=%0d takeoff=%0d id=%0d", lv, li, tv, ti);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            land_req    = 1'b0;
            takeoff_req = 1'b0;
            man_rel     = 2'b00;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            idle(1);
            n++;
        end
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
        check({tag, "_grant_is_landing"}, 32'(grant_is_landing), 32'd0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        check({tag, "_grant_runway"}, 32'(grant_runway), 32'd0);
        check({tag, "_runway_busy"}, 32'(runway_busy), 32'd0);
        check({tag, "_land_count"}, 32'(land_count), 32'd0);
        check({tag, "_takeoff_count"}, 32'(takeoff_count), 32'd0);
        check({tag, "_land_overflow"}, 32'(land_overflow), 32'd0);
        check({tag, "_takeoff_overflow"}, 32'(takeoff_overflow), 32'd0);
        check({tag, "_sched_state"}, 32'(sched_state), 32'd0);
    endtask

    initial begin
        int n;
        #1 RST = 1'b1;
        repeat (2) @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b0;

        // 1: single landing, exact latency and one-cycle pulse
        expect_grant(1'b1, 4'd5, 1'b0);
        drive(1'b1, 4'd5, 1'b0, 4'd0);
        idle(1);
        check("t1_latency_early", 32'(grant_valid), 32'd0);
        idle(1);
        check("t1_grant_valid", 32'(grant_valid), 32'd1);
        check("t1_runway_busy", 32'(runway_busy), 32'b01);
        check("t1_land_count", 32'(land_count), 32'd0);
        check("t1_sched_state", 32'(sched_state), 32'b01);
        idle(1);
        check("t1_pulse_width", 32'(grant_valid), 32'd0);
        man_rel = 2'b01;
        idle(6);
        check("t1_released", 32'(runway_busy), 32'b00);

        // 2: streak limit lets the takeoff through after three landings
        gcyc.delete();
        auto_en = 1'b1;
        expect_grant(1'b1, 4'd1, 1'b0);
        expect_grant(1'b1, 4'd2, 1'b0);
        expect_grant(1'b1, 4'd3, 1'b0);
        expect_grant(1'b0, 4'd9, 1'b0);
        expect_grant(1'b1, 4'd4, 1'b0);
        drive(1'b1, 4'd1, 1'b1, 4'd9);
        drive(1'b1, 4'd2, 1'b0, 4'd0);
        drive(1'b1, 4'd3, 1'b0, 4'd0);
        drive(1'b1, 4'd4, 1'b0, 4'd0);
        idle(1);
        check("t2_land_count", 32'(land_count), 32'd3);
        check("t2_takeoff_count", 32'(takeoff_count), 32'd1);
        wait_drain(100);
        idle(2);
        auto_en = 1'b0;
        check("t2_grant_total", 32'(gcyc.size()), 32'd5);
        for (int i = 1; i < gcyc.size(); i++) begin
            check("t2_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd5);
        end
        idle(3);

        // 3: high risk grants landings on runway 0 only
        ECSU_state = 2'b10;
        expect_grant(1'b1, 4'd3, 1'b0);
        drive(1'b1, 4'd3, 1'b1, 4'd7);
        wait_drain(50);
        idle(10);
        check("t3_takeoff_count", 32'(takeoff_count), 32'd1);
        check("t3_runway_busy", 32'(runway_busy), 32'b01);
        check("t3_sched_state", 32'(sched_state), 32'b00);
        expect_grant(1'b0, 4'd7, 1'b1);
        ECSU_state = 2'b00;
        wait_drain(20);
        check("t3_both_busy", 32'(runway_busy), 32'b11);
        man_rel = 2'b11;
        idle(6);

        // 4: emergency blocks grants; overflow is sticky
        auto_en = 1'b1;
        ECSU_state = 2'b11;
        for (int i = 1; i <= 5; i++) drive(1'b1, 4'(i), 1'b0, 4'd0);
        idle(5);
        check("t4_land_count", 32'(land_count), 32'd4);
        check("t4_land_overflow", 32'(land_overflow), 32'd1);
        check("t4_takeoff_overflow", 32'(takeoff_overflow), 32'd0);
        for (int i = 1; i <= 4; i++) expect_grant(1'b1, 4'(i), 1'b0);
        ECSU_state = 2'b00;
        wait_drain(100);
        idle(2);
        check("t4_overflow_sticky", 32'(land_overflow), 32'd1);
        check("t4_land_empty", 32'(land_count), 32'd0);
        auto_en = 1'b0;
        idle(2);

        // 5: caution waits for both runways to be free
        expect_grant(1'b1, 4'd6, 1'b0);
        drive(1'b1, 4'd6, 1'b0, 4'd0);
        wait_drain(20);
        idle(1);
        check("t5_busy_before", 32'(runway_busy), 32'b01);
        ECSU_state = 2'b01;
        drive(1'b1, 4'd7, 1'b0, 4'd0);
        drive(1'b1, 4'd8, 1'b0, 4'd0);
        idle(10);
        check("t5_land_count", 32'(land_count), 32'd2);
        expect_grant(1'b1, 4'd7, 1'b0);
        man_rel = 2'b01;
        n = 0;
        while (grant_valid !== 1'b1 && n < 20) begin
            idle(1);
            n++;
        end
        check("t5_grant_seen", 32'(grant_valid), 32'd1);
        idle(1);
        check("t5_in_hold", 32'(sched_state), 32'b11);
        check("t5_busy_after", 32'(runway_busy), 32'b01);

        // 6: asynchronous reset in the middle of HOLD
        #2 RST = 1'b1;
        #1 check_all_zero("t6_async");
        @(negedge CLK);
        RST = 1'b0;
        idle(15);
        check("t6_land_count", 32'(land_count), 32'd0);
        check("t6_state_idle", 32'(sched_state), 32'b00);
        check("t6_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
